// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_sequencer_pkg;

   // Sequencer states; the encodings are fixed so that waveforms and
   // debug probes read the same across every build of this block.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_RELEASE = 2'd2
   } state_e;

   // Width of the stage index: a single output still gets one bit.
   function automatic int stage_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Interval timer: counts up from zero and flags when it reaches the
// terminal value. Shared by the hold interval and the stage gaps.
module reset_seq_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   // Clear has priority so a new interval always starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == term);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: asserts every reset output together, holds
// them for ASSERT_CYCLES, then releases them one by one, lowest first.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_OUT       = 4,
   parameter int ASSERT_CYCLES = 16,
   parameter int STAGE_GAP     = 4,
   parameter int CNT_W         = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req,
   output logic [NUM_OUT-1:0] reset_out,
   output logic               busy,
   output logic               done
);

   localparam int               SW     = stage_w(NUM_OUT);
   localparam logic [CNT_W-1:0] A_TERM = CNT_W'(ASSERT_CYCLES - 1);
   localparam logic [CNT_W-1:0] G_TERM = CNT_W'(STAGE_GAP - 1);
   localparam logic [SW-1:0]    LAST   = SW'(NUM_OUT - 1);

   // Refuse to elaborate with parameters the counters cannot represent.
   if (NUM_OUT < 1) begin : g_chk_num
      $error("reset_sequencer: NUM_OUT must be >= 1");
   end
   if (ASSERT_CYCLES < 1 || STAGE_GAP < 1) begin : g_chk_cyc
      $error("reset_sequencer: ASSERT_CYCLES and STAGE_GAP must be >= 1");
   end
   if (CNT_W < 1 || CNT_W > 30 ||
       (ASSERT_CYCLES - 1) >= (1 << CNT_W) ||
       (STAGE_GAP - 1) >= (1 << CNT_W)) begin : g_chk_w
      $error("reset_sequencer: CNT_W too small for the configured intervals");
   end

   state_e             state_q, state_d;
   logic [NUM_OUT-1:0] ro_q, ro_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pend_q, pend_d;
   logic [SW-1:0]      stage_q, stage_d;
   logic               tmr_clr, tmr_en, tmr_tc;
   logic [CNT_W-1:0]   tmr_term;

   // The hold and gap intervals share one timer; only the terminal moves.
   assign tmr_term = (state_q == S_RELEASE) ? G_TERM : A_TERM;

   reset_seq_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .term  (tmr_term),
      .tc    (tmr_tc)
   );

   // Next-state, next-output and timer control.
   always_comb begin
      state_d = state_q;
      ro_d    = ro_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pend_d  = pend_q;
      stage_d = stage_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req || pend_q) begin
               state_d = S_ASSERT;
               ro_d    = '1;
               busy_d  = 1'b1;
               pend_d  = 1'b0;
               tmr_clr = 1'b1;
            end
         end
         S_ASSERT: begin
            // Any request seen while busy, even on the completing edge,
            // is remembered as one more sequence.
            pend_d = pend_q | req;
            tmr_en = 1'b1;
            if (tmr_tc) begin
               tmr_clr  = 1'b1;
               ro_d[0]  = 1'b0;
               stage_d  = SW'(1);
               if (NUM_OUT == 1) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  ro_d    = '0;
               end else begin
                  state_d = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            pend_d = pend_q | req;
            tmr_en = 1'b1;
            if (tmr_tc) begin
               tmr_clr = 1'b1;
               ro_d    = ro_q & ~(NUM_OUT'(1) << stage_q);
               stage_d = stage_q + SW'(1);
               if (stage_q == LAST) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  ro_d    = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            ro_d    = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops straight into the hold phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_ASSERT;
         ro_q    <= '1;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         pend_q  <= 1'b0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         ro_q    <= ro_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
         stage_q <= stage_d;
      end
   end

   assign reset_out = ro_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default build plus a one-output, one-cycle
// build. Expected outputs come from the absolute release timing.
module tb_reset_sequencer;

   typedef struct packed {
      logic [3:0] ro;
      logic       busy;
      logic       done;
   } exp_t;

   typedef struct {
      int         cyc;
      logic [3:0] ro;
      logic       busy;
      logic       done;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rst1_n = 1'b0;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [3:0] ro0;
   logic       busy0, done0;
   logic [0:0] ro1;
   logic       busy1, done1;
   exp_t       got0, got1;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   reset_sequencer #(.NUM_OUT(4), .ASSERT_CYCLES(16), .STAGE_GAP(4), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0),
      .reset_out(ro0), .busy(busy0), .done(done0)
   );

   reset_sequencer #(.NUM_OUT(1), .ASSERT_CYCLES(1), .STAGE_GAP(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst1_n), .req(req1),
      .reset_out(ro1), .busy(busy1), .done(done1)
   );

   assign got0 = {ro0, busy0, done0};
   assign got1 = {3'b000, ro1, busy1, done1};

   // c = edges elapsed since the sequence start (power-on: edges since
   // rst_n release; request: edges after the sampling edge).
   function automatic exp_t f(input int c, input int n, input int a, input int g);
      exp_t e;
      int   last;
      last   = a + (n - 1) * g;
      e.ro   = 4'h0;
      for (int k = 0; k < n; k++) e.ro[k] = (c < a + k * g);
      e.busy = (c < last);
      e.done = (c == last);
      return e;
   endfunction

   function automatic exp_t f4(input int c);
      return f(c, 4, 16, 4);
   endfunction

   function automatic exp_t f1(input int c);
      return f(c, 1, 1, 1);
   endfunction

   task automatic chk(input string nm, input exp_t got, input exp_t e);
      n_cmp++;
      if (got !== e) begin
         n_bad++;
         $display("FAIL %s: got ro=%h busy=%b done=%b, expected ro=%h busy=%b done=%b",
                  nm, got.ro, got.busy, got.done, e.ro, e.busy, e.done);
      end
   endtask

   // Drive req for one edge, queue the expected result, compare after it.
   task automatic step(input bit sel, input logic r, input exp_t e, input string nm);
      exp_t x;
      if (sel) req1 = r; else req0 = r;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      x = exp_q.pop_front();
      chk(nm, sel ? got1 : got0, x);
   endtask

   initial begin
      vec_t tbl[11];
      int   cur, ndone, last_d;

      tbl[0]  = '{0,  4'hF, 1'b1, 1'b0};
      tbl[1]  = '{1,  4'hF, 1'b1, 1'b0};
      tbl[2]  = '{15, 4'hF, 1'b1, 1'b0};
      tbl[3]  = '{16, 4'hE, 1'b1, 1'b0};
      tbl[4]  = '{19, 4'hE, 1'b1, 1'b0};
      tbl[5]  = '{20, 4'hC, 1'b1, 1'b0};
      tbl[6]  = '{24, 4'h8, 1'b1, 1'b0};
      tbl[7]  = '{27, 4'h8, 1'b1, 1'b0};
      tbl[8]  = '{28, 4'h0, 1'b0, 1'b1};
      tbl[9]  = '{29, 4'h0, 1'b0, 1'b0};
      tbl[10] = '{31, 4'h0, 1'b0, 1'b0};

      // 1: power-on sequence
      repeat (5) @(negedge clk);
      chk("por_in_reset", got0, {tbl[0].ro, tbl[0].busy, tbl[0].done});
      rst_n = 1'b1;
      cur = 0;
      for (int i = 1; i < 11; i++) begin
         while (cur < tbl[i].cyc) begin
            @(posedge clk);
            @(negedge clk);
            cur++;
         end
         chk($sformatf("por_edge%0d", tbl[i].cyc), got0,
             {tbl[i].ro, tbl[i].busy, tbl[i].done});
      end

      // 2: single request from IDLE
      ndone = 0;
      step(1'b0, 1'b1, f4(0), "req_j0");
      for (int j = 1; j <= 32; j++) begin
         step(1'b0, 1'b0, f4(j), $sformatf("req_j%0d", j));
         if (done0) ndone++;
      end
      n_cmp++;
      if (ndone != 1) begin
         n_bad++;
         $display("FAIL req_done_count: got %0d, expected 1", ndone);
      end

      // 3: two requests while busy coalesce into one more sequence
      ndone = 0;
      step(1'b0, 1'b1, f4(0), "coal_j0");
      for (int j = 1; j <= 63; j++) begin
         step(1'b0, (j == 5 || j == 10), (j < 29) ? f4(j) : f4(j - 29),
              $sformatf("coal_j%0d", j));
         if (done0) ndone++;
      end
      n_cmp++;
      if (ndone != 2) begin
         n_bad++;
         $display("FAIL coal_done_count: got %0d, expected 2", ndone);
      end

      // 4: reset mid-sequence, with a pending request that must be lost
      step(1'b0, 1'b1, f4(0), "mid_j0");
      for (int j = 1; j <= 18; j++)
         step(1'b0, (j == 5), f4(j), $sformatf("mid_j%0d", j));
      rst_n = 1'b0;
      #1;
      chk("mid_async_reset", got0, {4'hF, 1'b1, 1'b0});
      @(negedge clk);
      @(negedge clk);
      chk("mid_reset_held", got0, {4'hF, 1'b1, 1'b0});
      rst_n = 1'b1;
      for (int k = 1; k <= 36; k++)
         step(1'b0, 1'b0, f4(k), $sformatf("mid_por_edge%0d", k));

      // 6: req held for 100 edges, sequences repeat every 29 edges
      ndone = 0;
      last_d = -1;
      for (int j = 0; j <= 150; j++) begin
         step(1'b0, (j < 100), (j < 145) ? f4(j % 29) : f4(100),
              $sformatf("held_j%0d", j));
         if (done0) begin
            if (last_d >= 0) begin
               n_cmp++;
               if (j - last_d != 29) begin
                  n_bad++;
                  $display("FAIL held_done_spacing: got %0d, expected 29", j - last_d);
               end
            end
            last_d = j;
            ndone++;
         end
      end
      n_cmp++;
      if (ndone != 5) begin
         n_bad++;
         $display("FAIL held_done_count: got %0d, expected 5", ndone);
      end

      // 5: one output, one-cycle hold, req held high
      chk("n1_in_reset", got1, f1(0));
      req1 = 1'b1;
      rst1_n = 1'b1;
      for (int k = 1; k <= 10; k++)
         step(1'b1, 1'b1, (k % 2 == 1) ? f1(1) : f1(0), $sformatf("n1_edge%0d", k));
      step(1'b1, 1'b0, f1(1), "n1_last_done");
      step(1'b1, 1'b0, f1(5), "n1_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
